// File: rtl/di_frame_capture.sv
// di_frame_capture
//   Hunts for a two-byte sync header on DI, reads a word count N, then
//   captures N payload words {DID,DI} into a first-word-fall-through FIFO
//   with SOF/EOF tags, and finally compares an XOR check byte.
//
// Ports
//   QCLK        clock, rising edge
//   RST_N       asynchronous active-low reset (release synchronised inside)
//   DI, DID     8-bit data lanes (DID only meaningful during payload)
//   DOUT*       FIFO head: data, SOF, EOF, VALID; DOUT_READY pops the head
//   FRAME_OK    one-cycle pulse, check byte matched
//   CHK_ERR     one-cycle pulse, check byte mismatch or zero length
//   OVF         sticky, a payload word was dropped on a full FIFO
//   FRAME_CNT   saturating count of FRAME_OK pulses
//   ERR_CNT     saturating count of CHK_ERR pulses
module di_frame_capture #(
    parameter logic [15:0] SYNC_WORD = 16'hEB90,
    parameter int          FIFO_AW   = 4
) (
    input  logic        QCLK,
    input  logic        RST_N,
    input  logic [7:0]  DI,
    input  logic [7:0]  DID,
    output logic [15:0] DOUT,
    output logic        DOUT_SOF,
    output logic        DOUT_EOF,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY,
    output logic        FRAME_OK,
    output logic        CHK_ERR,
    output logic        OVF,
    output logic [15:0] FRAME_CNT,
    output logic [15:0] ERR_CNT
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {HUNT, HDR2, LEN, PAYLOAD, CHECK} state_t;

    // Reset asserts asynchronously but releases two edges after RST_N rises.
    logic [1:0] rst_sync;
    logic       rst_n_i;

    always_ff @(posedge QCLK or negedge RST_N) begin
        if (!RST_N) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    logic [7:0] di_q, did_q;
    state_t     state, nstate;
    logic [7:0] len_r, wcnt, csum;
    logic       wr_req, ok_set, err_set, last_word;

    // FIFO signals
    logic [17:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   mem_cnt, occ;
    logic               pop, load, full, wr_en;

    always_ff @(posedge QCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            di_q  <= 8'h00;
            did_q <= 8'h00;
        end else begin
            di_q  <= DI;
            did_q <= DID;
        end
    end

    assign last_word = (wcnt == len_r - 8'd1);

    always_ff @(posedge QCLK or negedge rst_n_i) begin
        if (!rst_n_i) state <= HUNT;
        else          state <= nstate;
    end

    always_comb begin
        nstate  = state;
        wr_req  = 1'b0;
        ok_set  = 1'b0;
        err_set = 1'b0;
        case (state)
            HUNT: if (di_q == SYNC_WORD[15:8]) nstate = HDR2;
            HDR2: begin
                if (di_q == SYNC_WORD[7:0])       nstate = LEN;
                else if (di_q == SYNC_WORD[15:8]) nstate = HDR2;
                else                              nstate = HUNT;
            end
            LEN: begin
                if (di_q == 8'h00) begin
                    err_set = 1'b1;
                    nstate  = HUNT;
                end else begin
                    nstate  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                wr_req = 1'b1;
                if (last_word) nstate = CHECK;
            end
            CHECK: begin
                if (di_q == csum) ok_set  = 1'b1;
                else              err_set = 1'b1;
                nstate = HUNT;
            end
            default: nstate = HUNT;
        endcase
    end

    // Frame datapath, status pulses and saturating counters
    always_ff @(posedge QCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            len_r     <= 8'h00;
            wcnt      <= 8'h00;
            csum      <= 8'h00;
            FRAME_OK  <= 1'b0;
            CHK_ERR   <= 1'b0;
            FRAME_CNT <= 16'h0000;
            ERR_CNT   <= 16'h0000;
        end else begin
            if (state == LEN && di_q != 8'h00) begin
                len_r <= di_q;
                wcnt  <= 8'h00;
                csum  <= 8'h00;
            end
            if (state == PAYLOAD) begin
                wcnt <= wcnt + 8'd1;
                csum <= csum ^ di_q ^ did_q;
            end
            FRAME_OK <= ok_set;
            CHK_ERR  <= err_set;
            if (ok_set && FRAME_CNT != 16'hFFFF) FRAME_CNT <= FRAME_CNT + 16'd1;
            if (err_set && ERR_CNT != 16'hFFFF)  ERR_CNT   <= ERR_CNT + 16'd1;
        end
    end

    // FIFO: RAM plus a registered head. Occupancy counts both, so the
    // total capacity is exactly DEPTH words and a fresh word needs one
    // extra cycle to reach the head.
    assign pop   = DOUT_VALID & DOUT_READY;
    assign load  = (mem_cnt != '0) && (!DOUT_VALID || pop);
    assign occ   = mem_cnt + (FIFO_AW+1)'(DOUT_VALID);
    assign full  = (occ == (FIFO_AW+1)'(DEPTH));
    assign wr_en = wr_req && (!full || pop);

    always_ff @(posedge QCLK) begin
        if (wr_en) mem[wr_ptr] <= {wcnt == 8'h00, last_word, did_q, di_q};
    end

    always_ff @(posedge QCLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            DOUT       <= 16'h0000;
            DOUT_SOF   <= 1'b0;
            DOUT_EOF   <= 1'b0;
            DOUT_VALID <= 1'b0;
            OVF        <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (FIFO_AW)'(1);
            if (load)  rd_ptr <= rd_ptr + (FIFO_AW)'(1);
            mem_cnt <= mem_cnt + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(load);
            if (load) begin
                {DOUT_SOF, DOUT_EOF, DOUT} <= mem[rd_ptr];
                DOUT_VALID <= 1'b1;
            end else if (pop) begin
                DOUT_VALID <= 1'b0;
            end
            if (wr_req && full && !pop) OVF <= 1'b1;
        end
    end
endmodule
